// File: rtl/spi_dpram_ctrl.sv
// Command-decoding memory stage behind the SPI slave: latches write/read
// addresses, writes a byte-wide RAM and returns read bytes after RD_LATENCY cycles.
module spi_dpram_ctrl #(
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_SIZE  = 8,
  parameter int RD_LATENCY = 1,
  parameter int AUTO_INC   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  logic [7:0]           mem_q [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_vld_q, wr_vld_d;
  logic                 rd_vld_q, rd_vld_d;
  logic                 err_q, err_d;
  logic                 mem_we;
  logic                 rd_fire;
  logic [7:0]           rd_byte;
  cmd_e                 cmd;

  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [7:0]            pipe_dat_q [RD_LATENCY];

  assign cmd     = cmd_e'(rx_data[9:8]);
  assign rd_byte = mem_q[rd_addr_q];

  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_vld_d  = wr_vld_q;
    rd_vld_d  = rd_vld_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    rd_fire   = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_d = rx_data[ADDR_SIZE-1:0];
          wr_vld_d  = 1'b1;
        end
        CMD_WR_DATA: begin
          if (wr_vld_q) begin
            mem_we = 1'b1;
            if (AUTO_INC != 0) wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d = rx_data[ADDR_SIZE-1:0];
          rd_vld_d  = 1'b1;
        end
        CMD_RD_DATA: begin
          if (rd_vld_q) begin
            rd_fire = 1'b1;
            if (AUTO_INC != 0) rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_vld_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_vld_q  <= wr_vld_d;
      rd_vld_q  <= rd_vld_d;
      err_q     <= err_d;
    end
  end

  // Memory is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr_q] <= rx_data[7:0];
  end

  // Each stage only loads on a valid beat, so the last stage holds the previous byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_dat_q[i] <= '0;
    end else begin
      pipe_vld_q[0] <= rd_fire;
      if (rd_fire) pipe_dat_q[0] <= rd_byte;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
    end
  end

  // Outputs are masked while rst is high so an in-flight read never escapes.
  assign tx_valid = pipe_vld_q[RD_LATENCY-1] & ~rst;
  assign tx_data  = rst ? '0 : pipe_dat_q[RD_LATENCY-1];
  assign cmd_err  = err_q & ~rst;

endmodule

// File: tb/tb_spi_dpram_ctrl.sv
// Scoreboard bench: three DUT variants share one rx bus; a reference model
// queues expected tx/cmd_err events per DUT and the monitor checks them each cycle.
module tb_spi_dpram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [9:0] rx_data = '0;
  logic [2:0] txv;
  logic [2:0] errv;
  logic [7:0] txd [3];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    logic [7:0] d;
  } exp_t;

  exp_t       rq [3][$];
  int         eq [3][$];
  logic [7:0] last_d [3];
  int         lat [3] = '{1, 2, 1};
  int         mdl [3] = '{0, 0, 1};

  logic [7:0] mmem [2][256];
  logic [7:0] mwa [2];
  logic [7:0] mra [2];
  bit         mwv [2];
  bit         mrv [2];

  spi_dpram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .RD_LATENCY(1), .AUTO_INC(0)) u_l1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(txd[0]), .tx_valid(txv[0]), .cmd_err(errv[0]));

  spi_dpram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .RD_LATENCY(2), .AUTO_INC(0)) u_l2 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(txd[1]), .tx_valid(txv[1]), .cmd_err(errv[1]));

  spi_dpram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .RD_LATENCY(1), .AUTO_INC(1)) u_inc (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(txd[2]), .tx_valid(txv[2]), .cmd_err(errv[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    for (int i = 0; i < 3; i++) begin
      bit   ev;
      bit   ee;
      exp_t e;
      if (rst) begin
        rq[i].delete();
        eq[i].delete();
        last_d[i] = '0;
      end
      ev = (rq[i].size() > 0) && (rq[i][0].due == cyc);
      if (ev) begin
        e = rq[i].pop_front();
        last_d[i] = e.d;
      end
      chk($sformatf("tx_valid[%0d]", i), 32'(txv[i]), 32'(ev));
      chk($sformatf("tx_data[%0d]", i), 32'(txd[i]), 32'(last_d[i]));
      ee = (eq[i].size() > 0) && (eq[i][0] == cyc);
      if (ee) void'(eq[i].pop_front());
      chk($sformatf("cmd_err[%0d]", i), 32'(errv[i]), 32'(ee));
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] c, input logic [7:0] p);
    @(posedge clk);
    #1;
    rst      = r;
    rx_valid = v;
    rx_data  = {c, p};
    for (int m = 0; m < 2; m++) begin
      bit         rd;
      bit         er;
      logic [7:0] d;
      rd = 1'b0;
      er = 1'b0;
      d  = '0;
      if (r) begin
        mwa[m] = '0; mra[m] = '0; mwv[m] = 1'b0; mrv[m] = 1'b0;
      end else if (v) begin
        case (c)
          2'd0: begin mwa[m] = p; mwv[m] = 1'b1; end
          2'd1: begin
            if (mwv[m]) begin
              mmem[m][mwa[m]] = p;
              if (m == 1) mwa[m] = mwa[m] + 8'd1;
            end else er = 1'b1;
          end
          2'd2: begin mra[m] = p; mrv[m] = 1'b1; end
          default: begin
            if (mrv[m]) begin
              d  = mmem[m][mra[m]];
              rd = 1'b1;
              if (m == 1) mra[m] = mra[m] + 8'd1;
            end else er = 1'b1;
          end
        endcase
      end
      for (int i = 0; i < 3; i++) begin
        if (mdl[i] == m) begin
          exp_t e;
          e.due = cyc + lat[i];
          e.d   = d;
          if (rd) rq[i].push_back(e);
          if (er) eq[i].push_back(cyc + 1);
        end
      end
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    logic [7:0] vals [4];
    vals = '{8'hC3, 8'h5A, 8'h0F, 8'hF0};
    for (int i = 0; i < 3; i++) last_d[i] = '0;

    step(1'b1, 1'b0, 2'd0, 8'h00);
    step(1'b1, 1'b0, 2'd0, 8'h00);

    // data commands with no address latched
    step(1'b0, 1'b1, 2'd3, 8'h00);
    step(1'b0, 1'b1, 2'd1, 8'h33);
    idle(3);

    // basic write then read
    step(1'b0, 1'b1, 2'd0, 8'h12);
    step(1'b0, 1'b1, 2'd1, 8'hA5);
    step(1'b0, 1'b1, 2'd2, 8'h12);
    step(1'b0, 1'b1, 2'd3, 8'h00);
    idle(3);

    // address wrap at FF
    step(1'b0, 1'b1, 2'd0, 8'hFF);
    step(1'b0, 1'b1, 2'd1, 8'h11);
    step(1'b0, 1'b1, 2'd1, 8'h22);
    step(1'b0, 1'b1, 2'd2, 8'hFF);
    step(1'b0, 1'b1, 2'd3, 8'h5C);
    step(1'b0, 1'b1, 2'd3, 8'hE7);
    idle(3);

    // back-to-back reads
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 2'd0, 8'h40 + 8'(k));
      step(1'b0, 1'b1, 2'd1, vals[k]);
    end
    step(1'b0, 1'b1, 2'd2, 8'h40);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 2'd3, 8'h00);
    idle(3);

    // write at N, read same address at N+1
    step(1'b0, 1'b1, 2'd0, 8'h50);
    step(1'b0, 1'b1, 2'd2, 8'h50);
    step(1'b0, 1'b1, 2'd1, 8'h9C);
    step(1'b0, 1'b1, 2'd3, 8'h00);
    idle(3);

    // reset right after a read strobe
    step(1'b0, 1'b1, 2'd2, 8'h12);
    step(1'b0, 1'b1, 2'd3, 8'h00);
    step(1'b1, 1'b0, 2'd0, 8'h00);
    idle(3);
    step(1'b0, 1'b1, 2'd2, 8'h12);
    step(1'b0, 1'b1, 2'd3, 8'h00);
    idle(3);

    // rx_data toggling with rx_valid low
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 2'($urandom), 8'($urandom));
    step(1'b0, 1'b1, 2'd2, 8'h12);
    step(1'b0, 1'b1, 2'd3, 8'h00);
    step(1'b0, 1'b1, 2'd2, 8'h40);
    step(1'b0, 1'b1, 2'd3, 8'h00);
    step(1'b0, 1'b1, 2'd2, 8'h50);
    step(1'b0, 1'b1, 2'd3, 8'h00);
    idle(4);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rd_pending[%0d]", i), 32'(rq[i].size()), 32'd0);
      chk($sformatf("err_pending[%0d]", i), 32'(eq[i].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
